// File: rtl/mac_sequencer.sv
// Sequencer that feeds an unpipelined MAC one dot product at a time.
// Takes a bias token and K operand pairs, then returns the MAC's final result.
module mac_sequencer #(
  parameter int INW  = 16,
  parameter int OUTW = 64,
  parameter int K    = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start_valid,
  output logic            start_ready,
  input  logic [INW-1:0]  start_bias,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [INW-1:0]  in_a,
  input  logic [INW-1:0]  in_b,
  output logic [INW-1:0]  mac_init_value,
  output logic            mac_init_acc,
  output logic [INW-1:0]  mac_in0,
  output logic [INW-1:0]  mac_in1,
  output logic            mac_input_valid,
  input  logic [OUTW-1:0] mac_out,
  output logic [OUTW-1:0] out_data,
  output logic            out_valid,
  input  logic            out_ready
);

  localparam int CW = $clog2(K + 1);
  localparam logic [CW-1:0] LAST = CW'(K - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    DRAIN,
    OUT
  } state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic            drain_q;
  logic            init_acc_q;
  logic [INW-1:0]  init_value_q;
  logic [INW-1:0]  in0_q;
  logic [INW-1:0]  in1_q;
  logic            ivalid_q;
  logic [OUTW-1:0] out_data_q;
  logic            out_valid_q;

  logic start_fire;
  logic beat_fire;
  logic out_fire;

  // Readies are held low while reset is asserted so nothing looks accepted.
  assign start_ready = (state_q == IDLE) && !reset;
  assign in_ready    = (state_q == ACC) && !reset;

  assign start_fire = start_valid && start_ready;
  assign beat_fire  = in_valid && in_ready;
  assign out_fire   = out_valid_q && out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      drain_q      <= 1'b0;
      init_acc_q   <= 1'b0;
      init_value_q <= '0;
      in0_q        <= '0;
      in1_q        <= '0;
      ivalid_q     <= 1'b0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
    end else begin
      init_acc_q <= 1'b0;
      ivalid_q   <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start_fire) begin
            init_acc_q   <= 1'b1;
            init_value_q <= start_bias;
            cnt_q        <= '0;
            state_q      <= ACC;
          end
        end
        ACC: begin
          if (beat_fire) begin
            ivalid_q <= 1'b1;
            in0_q    <= in_a;
            in1_q    <= in_b;
            cnt_q    <= cnt_q + CW'(1);
            if (cnt_q == LAST) begin
              drain_q <= 1'b0;
              state_q <= DRAIN;
            end
          end
        end
        DRAIN: begin
          // Second drain cycle: the last product has landed in mac_out.
          if (drain_q) begin
            out_data_q  <= mac_out;
            out_valid_q <= 1'b1;
            state_q     <= OUT;
          end else begin
            drain_q <= 1'b1;
          end
        end
        OUT: begin
          if (out_fire) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
      endcase
    end
  end

  assign mac_init_acc    = init_acc_q;
  assign mac_init_value  = init_value_q;
  assign mac_in0         = in0_q;
  assign mac_in1         = in1_q;
  assign mac_input_valid = ivalid_q;
  assign out_data        = out_data_q;
  assign out_valid       = out_valid_q;

endmodule

// File: tb/tb_mac_sequencer.sv
// Bench for mac_sequencer with a behavioural MAC and a dot-product model.
// Table vectors, hand-written reset/back-to-back sequences and random jobs.
module tb_mac_sequencer;

  localparam int INW  = 16;
  localparam int OUTW = 64;
  localparam int K    = 4;

  logic            clk;
  logic            reset;
  logic            start_valid;
  logic            start_ready;
  logic [INW-1:0]  start_bias;
  logic            in_valid;
  logic            in_ready;
  logic [INW-1:0]  in_a;
  logic [INW-1:0]  in_b;
  logic [INW-1:0]  mac_init_value;
  logic            mac_init_acc;
  logic [INW-1:0]  mac_in0;
  logic [INW-1:0]  mac_in1;
  logic            mac_input_valid;
  logic [OUTW-1:0] mac_out;
  logic [OUTW-1:0] out_data;
  logic            out_valid;
  logic            out_ready;

  mac_sequencer #(.INW(INW), .OUTW(OUTW), .K(K)) dut (
    .clk             (clk),
    .reset           (reset),
    .start_valid     (start_valid),
    .start_ready     (start_ready),
    .start_bias      (start_bias),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_a            (in_a),
    .in_b            (in_b),
    .mac_init_value  (mac_init_value),
    .mac_init_acc    (mac_init_acc),
    .mac_in0         (mac_in0),
    .mac_in1         (mac_in1),
    .mac_input_valid (mac_input_valid),
    .mac_out         (mac_out),
    .out_data        (out_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Unpipelined MAC: init loads the bias, each valid beat adds one product.
  longint acc;
  always @(posedge clk) begin
    if (reset) acc <= 0;
    else if (mac_init_acc) acc <= longint'($signed(mac_init_value));
    else if (mac_input_valid)
      acc <= acc + longint'($signed(mac_in0)) * longint'($signed(mac_in1));
  end
  assign mac_out = acc;

  longint cyc;
  int     init_cnt;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (mac_init_acc) init_cnt <= init_cnt + 1;

  int n_pass;
  int n_chk;
  longint start_cyc;

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
                  nm, act, act, exp, exp);
  endtask

  task automatic chk_zero(input string tag);
    check({tag, " init_acc"}, 64'(mac_init_acc), 0);
    check({tag, " init_value"}, 64'(mac_init_value), 0);
    check({tag, " in0"}, 64'(mac_in0), 0);
    check({tag, " in1"}, 64'(mac_in1), 0);
    check({tag, " input_valid"}, 64'(mac_input_valid), 0);
    check({tag, " out_data"}, out_data, 0);
    check({tag, " out_valid"}, 64'(out_valid), 0);
    check({tag, " in_ready"}, 64'(in_ready), 0);
  endtask

  typedef logic [3:0][15:0] ops_t;

  function automatic logic [63:0] dot(input logic [15:0] bias,
                                      input ops_t a, input ops_t b);
    longint s;
    s = longint'($signed(bias));
    for (int i = 0; i < K; i++)
      s += longint'($signed(a[i])) * longint'($signed(b[i]));
    return s;
  endfunction

  function automatic ops_t mk4(input int x0, input int x1,
                               input int x2, input int x3);
    ops_t r;
    r[0] = 16'(x0);
    r[1] = 16'(x1);
    r[2] = 16'(x2);
    r[3] = 16'(x3);
    return r;
  endfunction

  // Called at a negedge; returns at a negedge just after the result handshake.
  task automatic run_job(input logic [15:0] bias, input ops_t a,
                         input ops_t b, input int gap, input int hold,
                         output logic [63:0] res);
    int  n;
    int  t;
    int  lat;
    int  init0;
    bit  fire;
    t = 0;
    while (!start_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("start_ready before job", 64'(start_ready), 1);
    start_valid = 1'b1;
    start_bias  = bias;
    init0       = init_cnt;
    @(posedge clk);
    start_cyc = cyc;
    @(negedge clk);
    start_valid = 1'b0;
    check("init_acc pulse", 64'(mac_init_acc), 1);
    check("init_value", 64'(mac_init_value), 64'(bias));
    n = 0;
    t = 0;
    while (n < K && t < 64) begin
      if (gap == 0) in_valid = 1'b1;
      else if (gap == 1) in_valid = (t % 2) == 0;
      else in_valid = 1'($urandom_range(0, 1));
      in_a = a[n];
      in_b = b[n];
      fire = in_valid && in_ready;
      @(posedge clk);
      @(negedge clk);
      check("input_valid mirrors accept", 64'(mac_input_valid), 64'(fire));
      check("init_acc low in ACC", 64'(mac_init_acc), 0);
      if (fire) begin
        check("mac_in0", 64'(mac_in0), 64'(a[n]));
        check("mac_in1", 64'(mac_in1), 64'(b[n]));
        n++;
      end else if (n > 0) begin
        check("mac_in0 hold", 64'(mac_in0), 64'(a[n-1]));
      end
      t++;
    end
    in_valid = 1'b0;
    if (n < K) check("beat timeout", 64'(n), 64'(K));
    lat = 0;
    while (!out_valid && lat < 10) begin
      in_valid = 1'b1;
      check("in_ready low in DRAIN", 64'(in_ready), 0);
      @(posedge clk);
      @(negedge clk);
      check("input_valid low in DRAIN", 64'(mac_input_valid), 0);
      lat++;
    end
    in_valid = 1'b0;
    check("result latency", 64'(lat), 2);
    res = out_data;
    out_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      in_valid    = 1'b1;
      start_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("out_valid held", 64'(out_valid), 1);
      check("out_data held", out_data, res);
      check("start_ready low in OUT", 64'(start_ready), 0);
      check("in_ready low in OUT", 64'(in_ready), 0);
      check("no MAC beat in OUT", 64'(mac_input_valid), 0);
      check("no init in OUT", 64'(mac_init_acc), 0);
    end
    in_valid    = 1'b0;
    start_valid = 1'b0;
    out_ready   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("out_valid drops", 64'(out_valid), 0);
    check("start_ready after handshake", 64'(start_ready), 1);
    check("one init pulse", 64'(init_cnt - init0), 1);
  endtask

  typedef struct packed {
    logic [15:0] bias;
    ops_t        a;
    ops_t        b;
    logic [1:0]  gap;
    logic [3:0]  hold;
    logic [63:0] exp;
  } vec_t;

  vec_t tbl[5];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [63:0] r;
    logic [63:0] r2;
    longint      s1;
    ops_t        ra;
    ops_t        rb;
    logic [15:0] rbias;

    n_pass = 0;
    n_chk  = 0;
    cyc = 0;
    init_cnt = 0;

    tbl[0] = '{16'd10, mk4(1, 2, 3, 4), mk4(5, 6, 7, 8), 2'd0, 4'd0, 64'd80};
    tbl[1] = '{16'hfffb, mk4(-3, 7, -32768, 1), mk4(7, -2, -32768, 0),
               2'd0, 4'd0, 64'd1073741784};
    tbl[2] = '{16'd10, mk4(1, 2, 3, 4), mk4(5, 6, 7, 8), 2'd1, 4'd0, 64'd80};
    tbl[3] = '{16'hfffb, mk4(-3, 7, -32768, 1), mk4(7, -2, -32768, 0),
               2'd1, 4'd5, 64'd1073741784};
    tbl[4] = '{16'd0, mk4(1, 1, 1, 1), mk4(1, 1, 1, 1), 2'd2, 4'd2, 64'd4};

    reset = 1'b1;
    start_valid = 1'b0;
    start_bias = '0;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero("reset");
    check("reset start_ready", 64'(start_ready), 0);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk_zero("post-reset");
    check("post-reset start_ready", 64'(start_ready), 1);

    for (int i = 0; i < 5; i++) begin
      run_job(tbl[i].bias, tbl[i].a, tbl[i].b, int'(tbl[i].gap),
              int'(tbl[i].hold), r);
      check($sformatf("table[%0d] result", i), r, tbl[i].exp);
      check($sformatf("table[%0d] model", i), r,
            dot(tbl[i].bias, tbl[i].a, tbl[i].b));
    end

    // Reset after the second beat abandons the job.
    start_valid = 1'b1;
    start_bias  = 16'd7;
    @(posedge clk);
    @(negedge clk);
    start_valid = 1'b0;
    in_valid = 1'b1;
    in_a = 16'd3;
    in_b = 16'd3;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_zero("mid-reset");
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk_zero("after mid-reset");
    check("after mid-reset start_ready", 64'(start_ready), 1);
    run_job(16'd0, mk4(1, 1, 1, 1), mk4(1, 1, 1, 1), 0, 0, r);
    check("fresh job after reset", r, 64'd4);

    // Back-to-back jobs at the minimum period.
    run_job(16'd1, mk4(2, 2, 2, 2), mk4(2, 2, 2, 2), 0, 0, r);
    s1 = start_cyc;
    run_job(16'd100, mk4(2, 2, 2, 2), mk4(2, 2, 2, 2), 0, 0, r2);
    check("b2b first result", r, 64'd17);
    check("b2b second result", r2, 64'd116);
    check("b2b period", 64'(start_cyc - s1), 64'(K + 4));

    for (int j = 0; j < 20; j++) begin
      rbias = 16'($urandom);
      for (int i = 0; i < K; i++) begin
        ra[i] = 16'($urandom);
        rb[i] = 16'($urandom);
      end
      run_job(rbias, ra, rb, int'($urandom_range(0, 2)),
              int'($urandom_range(0, 3)), r);
      check($sformatf("random job %0d", j), r, dot(rbias, ra, rb));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
